load_use_stall_ctrl: RTL and testbench
======================================

// Module: load_use_stall_ctrl
// PURPOSE
//  Consumer of the ID-stage load-use forward request. Holds IF/ID and injects EX bubbles until
//  the producing load's data is valid in LSU2, then pulses per-operand LSU2 forward hits to ID.
//  Sits beside the hazard logic between ID and the ID/EX pipeline register.
//  Waits through both fixed pipeline distance and variable D-cache latency.
// PARAMETERS
//  REG_ADDR_W       5  register index width
//  EX_LOAD_STALL    2  bubbles required when the load is in EX at detection
//  LSU1_LOAD_STALL  1  bubbles required when the load is in LSU1 at detection
//  CNT_W            2  stall counter width; must hold max(EX_LOAD_STALL, LSU1_LOAD_STALL)
// PORTS
//  clk              in   1           clock
//  resetn           in   1           async reset, active-low
//  forward_req_i    in   1           load-use hazard request (combinational, ID stage)
//  req_src_ex_i     in   1           1: producer load in EX; 0: producer load in LSU1
//  ex_w_reg_dst     in   REG_ADDR_W  EX destination register
//  lsu1_w_reg_dst   in   REG_ADDR_W  LSU1 destination register
//  id_rs            in   REG_ADDR_W  ID source register rs
//  id_rt            in   REG_ADDR_W  ID source register rt
//  lsu2_data_ok_i   in   1           load data valid in LSU2 this cycle
//  pipe_stall_i     in   1           global freeze (I-cache miss etc.)
//  flush_i          in   1           exception / branch flush
//  id_stall_o       out  1           hold PC and IF/ID
//  ex_bubble_o      out  1           write NOP into ID/EX
//  fwd_rs_lsu2_o    out  1           ID takes rs from the LSU2 result this cycle
//  fwd_rt_lsu2_o    out  1           ID takes rt from the LSU2 result this cycle
//  busy_o           out  1           state != IDLE
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, cnt=0, ld_dst=0.
//    All outputs 0 while in reset and on the first cycle after release.
//  - States: IDLE, STALL, WAIT_DATA, RELEASE. State and cnt advance only when pipe_stall_i=0.
//    When pipe_stall_i=1, state, cnt and all outputs hold.
//  - IDLE
//    - Effective request = forward_req_i & !flush_i & (selected dst != 0).
//    - Selected dst = req_src_ex_i ? ex_w_reg_dst : lsu1_w_reg_dst.
//    - On an effective request (Mealy, same cycle T): id_stall_o=1, ex_bubble_o=1.
//    - At T the selected dst is latched into ld_dst.
//    - cnt = (req_src_ex_i ? EX_LOAD_STALL : LSU1_LOAD_STALL) - 1.
//    - Next state: STALL if cnt>0, else WAIT_DATA.
//  - STALL: id_stall_o=1, ex_bubble_o=1; cnt decrements each cycle; at cnt==1 -> WAIT_DATA.
//  - WAIT_DATA: id_stall_o=1, ex_bubble_o=1.
//    - lsu2_data_ok_i=1 -> RELEASE.
//    - lsu2_data_ok_i=0 -> stay, with no upper bound.
//  - RELEASE (exactly one cycle, registered)
//    - id_stall_o=0, ex_bubble_o=0.
//    - fwd_rs_lsu2_o = (id_rs == ld_dst); fwd_rt_lsu2_o = (id_rt == ld_dst).
//    - Next state: IDLE.
//    - A new forward_req_i in RELEASE is not accepted; it is re-evaluated in IDLE.
//  - flush_i=1 in any state, including while pipe_stall_i=1, takes priority:
//    - id_stall_o, ex_bubble_o and fwd_* are forced to 0 the same cycle.
//    - Next state IDLE; cnt=0.
//  - Latency: EX-source load with zero-wait cache = stall cycles T, T+1, T+2; RELEASE at T+3.
//    LSU1 source: RELEASE at T+2.
//  - Outputs are 0 in IDLE unless an effective request is present.
//  - cnt never wraps: decrementing past 0 is illegal (assertion).
// STRUCTURE
//  - Shared pipeline package: state encoding localparams (IDLE=2'd0, STALL=2'd1,
//    WAIT_DATA=2'd2, RELEASE=2'd3); REG_ADDR_W; stall constants.
//  - Single flat module; no sub-module needed.
//  - Operand compare is inline: two REG_ADDR_W equality checks.
// TESTING
//  1. EX load dst=5, id_rs=5, data_ok at T+2
//     -> id_stall_o=1 at T..T+2; fwd_rs_lsu2_o=1, fwd_rt_lsu2_o=0 at T+3; IDLE at T+4.
//  2. LSU1 load dst=7 = id_rt = id_rs, data_ok at T+1
//     -> stall at T, T+1; both fwd_* =1 at T+2.
//  3. EX load, lsu2_data_ok_i low for 4 extra cycles
//     -> stall held in WAIT_DATA 4 more cycles; RELEASE the cycle after data_ok.
//  4. pipe_stall_i=1 for 3 cycles at T+1 -> cnt/state frozen; RELEASE delayed by exactly 3.
//  5. flush_i at T+1 during STALL -> stall/bubble 0 at T+1, busy_o=0 at T+2.
//     Also: forward_req_i with dst=0 -> no stall.
//  6. resetn low mid-WAIT_DATA -> all outputs 0 immediately (async); IDLE after release.

Source files
------------

// File: rtl/load_use_stall_ctrl_pkg.sv
// Shared pipeline constants and the state encoding for the load-use stall controller.
package load_use_stall_ctrl_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int EX_LOAD_STALL   = 2;
  localparam int LSU1_LOAD_STALL = 1;
  localparam int CNT_W           = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STALL     = 2'd1,
    WAIT_DATA = 2'd2,
    RELEASE   = 2'd3
  } state_t;

endpackage

// File: rtl/load_use_stall_ctrl.sv
// Holds IF/ID and bubbles EX on a load-use hazard until the load's data is valid in LSU2,
// then pulses per-operand LSU2 forward hits back to ID for one cycle.
module load_use_stall_ctrl #(
  parameter int REG_ADDR_W      = load_use_stall_ctrl_pkg::REG_ADDR_W,
  parameter int EX_LOAD_STALL   = load_use_stall_ctrl_pkg::EX_LOAD_STALL,
  parameter int LSU1_LOAD_STALL = load_use_stall_ctrl_pkg::LSU1_LOAD_STALL,
  parameter int CNT_W           = load_use_stall_ctrl_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  forward_req_i,
  input  logic                  req_src_ex_i,
  input  logic [REG_ADDR_W-1:0] ex_w_reg_dst,
  input  logic [REG_ADDR_W-1:0] lsu1_w_reg_dst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  lsu2_data_ok_i,
  input  logic                  pipe_stall_i,
  input  logic                  flush_i,
  output logic                  id_stall_o,
  output logic                  ex_bubble_o,
  output logic                  fwd_rs_lsu2_o,
  output logic                  fwd_rt_lsu2_o,
  output logic                  busy_o
);

  import load_use_stall_ctrl_pkg::*;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [REG_ADDR_W-1:0]   ld_dst;
  logic                    armed;
  logic [REG_ADDR_W-1:0]   sel_dst;
  logic [CNT_W-1:0]        cnt_init;
  logic                    accept;
  logic                    holding;

  // armed keeps the controller silent on the first cycle after reset release
  assign sel_dst  = req_src_ex_i ? ex_w_reg_dst : lsu1_w_reg_dst;
  assign cnt_init = req_src_ex_i ? CNT_W'(EX_LOAD_STALL - 1) : CNT_W'(LSU1_LOAD_STALL - 1);
  assign accept   = (state == IDLE) && armed && !pipe_stall_i && forward_req_i &&
                    !flush_i && (sel_dst != '0);
  assign holding  = (state == STALL) || (state == WAIT_DATA);

  assign id_stall_o    = !flush_i && (holding || accept);
  assign ex_bubble_o   = !flush_i && (holding || accept);
  assign fwd_rs_lsu2_o = !flush_i && (state == RELEASE) && (id_rs == ld_dst);
  assign fwd_rt_lsu2_o = !flush_i && (state == RELEASE) && (id_rt == ld_dst);
  assign busy_o        = (state != IDLE);

  // Flush wins even over a global freeze; otherwise nothing moves while frozen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      ld_dst <= '0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (!pipe_stall_i) begin
        case (state)
          IDLE: begin
            if (accept) begin
              ld_dst <= sel_dst;
              cnt    <= cnt_init;
              state  <= (cnt_init != '0) ? STALL : WAIT_DATA;
            end
          end
          STALL: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= WAIT_DATA;
          end
          WAIT_DATA: begin
            if (lsu2_data_ok_i) state <= RELEASE;
          end
          RELEASE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  cnt_no_wrap: assert property (@(posedge clk) disable iff (!resetn)
                                (state == STALL) |-> (cnt != '0));

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed scoreboard bench for load_use_stall_ctrl: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_load_use_stall_ctrl;

  logic       clk;
  logic       resetn;
  logic       forward_req_i;
  logic       req_src_ex_i;
  logic [4:0] ex_w_reg_dst;
  logic [4:0] lsu1_w_reg_dst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       lsu2_data_ok_i;
  logic       pipe_stall_i;
  logic       flush_i;
  logic       id_stall_o;
  logic       ex_bubble_o;
  logic       fwd_rs_lsu2_o;
  logic       fwd_rt_lsu2_o;
  logic       busy_o;

  typedef struct {
    logic [4:0] bits;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   release_pending = 0;

  load_use_stall_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .forward_req_i  (forward_req_i),
    .req_src_ex_i   (req_src_ex_i),
    .ex_w_reg_dst   (ex_w_reg_dst),
    .lsu1_w_reg_dst (lsu1_w_reg_dst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .lsu2_data_ok_i (lsu2_data_ok_i),
    .pipe_stall_i   (pipe_stall_i),
    .flush_i        (flush_i),
    .id_stall_o     (id_stall_o),
    .ex_bubble_o    (ex_bubble_o),
    .fwd_rs_lsu2_o  (fwd_rs_lsu2_o),
    .fwd_rt_lsu2_o  (fwd_rt_lsu2_o),
    .busy_o         (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected bits are {id_stall, ex_bubble, fwd_rs, fwd_rt, busy}
  task automatic checkOutput(input logic [4:0] exp, input string nm);
    logic [4:0] act;
    act = {id_stall_o, ex_bubble_o, fwd_rs_lsu2_o, fwd_rt_lsu2_o, busy_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // One cycle of inputs applied just after the rising edge, with its expected outputs
  task automatic applyStimulus(input logic fr, input logic src, input logic [4:0] exd,
                               input logic [4:0] l1d, input logic [4:0] rs,
                               input logic [4:0] rt, input logic ok, input logic ps,
                               input logic fl, input logic [4:0] exp, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (release_pending) begin
      resetn          = 1'b1;
      release_pending = 0;
    end
    forward_req_i  = fr;
    req_src_ex_i   = src;
    ex_w_reg_dst   = exd;
    lsu1_w_reg_dst = l1d;
    id_rs          = rs;
    id_rt          = rt;
    lsu2_data_ok_i = ok;
    pipe_stall_i   = ps;
    flush_i        = fl;
    e.bits = exp;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e.bits, e.name);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    forward_req_i  = 1'b0;
    req_src_ex_i   = 1'b0;
    ex_w_reg_dst   = '0;
    lsu1_w_reg_dst = '0;
    id_rs          = '0;
    id_rt          = '0;
    lsu2_data_ok_i = 1'b0;
    pipe_stall_i   = 1'b0;
    flush_i        = 1'b0;

    #12;
    checkOutput(5'b00000, "reset_state");

    release_pending = 1;
    applyStimulus(1, 1, 5, 0, 5, 3, 0, 0, 0, 5'b00000, "first_cycle_after_release");
    applyStimulus(0, 1, 5, 0, 5, 3, 0, 0, 0, 5'b00000, "idle_quiet");

    // EX-source load, zero-wait data; request held in RELEASE must be ignored
    applyStimulus(1, 1, 5, 0, 5, 3, 0, 0, 0, 5'b11000, "t1_accept");
    applyStimulus(0, 1, 5, 0, 5, 3, 0, 0, 0, 5'b11001, "t1_stall");
    applyStimulus(0, 1, 5, 0, 5, 3, 1, 0, 0, 5'b11001, "t1_wait_ok");
    applyStimulus(1, 1, 5, 0, 5, 3, 0, 0, 0, 5'b00101, "t1_release");
    applyStimulus(0, 1, 5, 0, 5, 3, 0, 0, 0, 5'b00000, "t1_idle");

    // LSU1-source load, both operands hit
    applyStimulus(1, 0, 9, 7, 7, 7, 0, 0, 0, 5'b11000, "t2_accept");
    applyStimulus(0, 0, 9, 7, 7, 7, 1, 0, 0, 5'b11001, "t2_wait_ok");
    applyStimulus(0, 0, 9, 7, 7, 7, 0, 0, 0, 5'b00111, "t2_release");
    applyStimulus(0, 0, 9, 7, 7, 7, 0, 0, 0, 5'b00000, "t2_idle");

    // EX load with four extra cache-miss cycles
    applyStimulus(1, 1, 4, 0, 2, 4, 0, 0, 0, 5'b11000, "t3_accept");
    applyStimulus(0, 1, 4, 0, 2, 4, 0, 0, 0, 5'b11001, "t3_stall");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 4, 0, 2, 4, 0, 0, 0, 5'b11001, "t3_wait_miss");
    applyStimulus(0, 1, 4, 0, 2, 4, 1, 0, 0, 5'b11001, "t3_wait_ok");
    applyStimulus(0, 1, 4, 0, 2, 4, 0, 0, 0, 5'b00011, "t3_release");
    applyStimulus(0, 1, 4, 0, 2, 4, 0, 0, 0, 5'b00000, "t3_idle");

    // Global freeze for three cycles while in STALL
    applyStimulus(1, 1, 6, 0, 1, 6, 0, 0, 0, 5'b11000, "t4_accept");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 6, 0, 1, 6, 0, 1, 0, 5'b11001, "t4_frozen");
    applyStimulus(0, 1, 6, 0, 1, 6, 0, 0, 0, 5'b11001, "t4_stall");
    applyStimulus(0, 1, 6, 0, 1, 6, 1, 0, 0, 5'b11001, "t4_wait_ok");
    applyStimulus(0, 1, 6, 0, 1, 6, 0, 0, 0, 5'b00011, "t4_release");
    applyStimulus(0, 1, 6, 0, 1, 6, 0, 0, 0, 5'b00000, "t4_idle");

    // Flush in STALL, zero destination, flush in IDLE, flush during freeze
    applyStimulus(1, 1, 3, 0, 3, 0, 0, 0, 0, 5'b11000, "t5_accept");
    applyStimulus(0, 1, 3, 0, 3, 0, 0, 0, 1, 5'b00001, "t5_flush");
    applyStimulus(0, 1, 3, 0, 3, 0, 0, 0, 0, 5'b00000, "t5_after_flush");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, "t5_dst0_ex");
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 5'b00000, "t5_dst0_lsu1");
    applyStimulus(0, 0, 5, 0, 0, 0, 0, 0, 0, 5'b00000, "t5_dst0_idle");
    applyStimulus(1, 1, 3, 0, 3, 0, 0, 0, 1, 5'b00000, "t5_flush_idle_req");
    applyStimulus(0, 1, 3, 0, 3, 0, 0, 0, 0, 5'b00000, "t5_flush_idle_after");
    applyStimulus(1, 1, 3, 0, 3, 0, 0, 0, 0, 5'b11000, "t5_accept2");
    applyStimulus(0, 1, 3, 0, 3, 0, 0, 1, 1, 5'b00001, "t5_flush_frozen");
    applyStimulus(0, 1, 3, 0, 3, 0, 0, 0, 0, 5'b00000, "t5_after_flush_frozen");

    // Asynchronous reset in the middle of WAIT_DATA
    applyStimulus(1, 1, 8, 0, 8, 0, 0, 0, 0, 5'b11000, "t6_accept");
    applyStimulus(0, 1, 8, 0, 8, 0, 0, 0, 0, 5'b11001, "t6_stall");
    applyStimulus(0, 1, 8, 0, 8, 0, 0, 0, 0, 5'b11001, "t6_wait");
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput(5'b00000, "t6_async_reset");
    release_pending = 1;
    applyStimulus(1, 0, 0, 8, 8, 0, 0, 0, 0, 5'b00000, "t6_first_after_release");
    applyStimulus(1, 0, 0, 8, 8, 0, 0, 0, 0, 5'b11000, "t6_idle_accept");
    applyStimulus(0, 0, 0, 8, 8, 0, 1, 0, 0, 5'b11001, "t6_wait_ok");
    applyStimulus(0, 0, 0, 8, 8, 0, 0, 0, 0, 5'b00101, "t6_release");
    applyStimulus(0, 0, 0, 8, 8, 0, 0, 0, 0, 5'b00000, "t6_idle");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
